ar_chan_route_reg: RTL and testbench

//  Registered, parametrised AR-channel router between the AR arbiter output and NUM_SLAVES slave ports.

---
 rtl/ar_chan_route_reg_if.sv | 55 +++++
 rtl/ar_chan_route_reg.sv | 106 ++++++++++
 tb/tb_ar_chan_route_reg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ar_chan_route_reg_if.sv
// ar_chan_route_reg_if: AR-channel router bus bundle; slave = router view, master = driving environment
// Signals: in_ar* upstream request, m_ar* per-slave packed requests (slice k = slave k),
//   err_* DECERR sink handshake, rd_done burst completion, route_sel/ost_count ordering status.
interface ar_chan_route_reg_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ID_W = 1,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 8,
  parameter int MAX_OST = 4
);
  localparam int OST_W = $clog2(MAX_OST + 1);
  logic [ID_W-1:0] in_arid;
  logic [ADDR_W-1:0] in_araddr;
  logic [LEN_W-1:0] in_arlen;
  logic [2:0] in_arsize;
  logic [1:0] in_arburst;
  logic [1:0] in_arlock;
  logic [3:0] in_arcache;
  logic [2:0] in_arprot;
  logic [3:0] in_arqos;
  logic [3:0] in_arregion;
  logic in_arvalid;
  logic in_arready;
  logic [NUM_SLAVES*ID_W-1:0] m_arid;
  logic [NUM_SLAVES*ADDR_W-1:0] m_araddr;
  logic [NUM_SLAVES*LEN_W-1:0] m_arlen;
  logic [NUM_SLAVES*3-1:0] m_arsize;
  logic [NUM_SLAVES*2-1:0] m_arburst;
  logic [NUM_SLAVES*2-1:0] m_arlock;
  logic [NUM_SLAVES*4-1:0] m_arcache;
  logic [NUM_SLAVES*3-1:0] m_arprot;
  logic [NUM_SLAVES*4-1:0] m_arqos;
  logic [NUM_SLAVES*4-1:0] m_arregion;
  logic [NUM_SLAVES-1:0] m_arvalid;
  logic [NUM_SLAVES-1:0] m_arready;
  logic err_valid;
  logic [ID_W-1:0] err_id;
  logic [LEN_W-1:0] err_len;
  logic err_ready;
  logic rd_done;
  logic [NUM_SLAVES:0] route_sel;
  logic [OST_W-1:0] ost_count;
  modport slave (
    input in_arid, in_araddr, in_arlen, in_arsize, in_arburst, in_arlock, in_arcache, in_arprot,
          in_arqos, in_arregion, in_arvalid, m_arready, err_ready, rd_done,
    output in_arready, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot,
           m_arqos, m_arregion, m_arvalid, err_valid, err_id, err_len, route_sel, ost_count
  );
  modport master (
    output in_arid, in_araddr, in_arlen, in_arsize, in_arburst, in_arlock, in_arcache, in_arprot,
           in_arqos, in_arregion, in_arvalid, m_arready, err_ready, rd_done,
    input in_arready, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot,
          m_arqos, m_arregion, m_arvalid, err_valid, err_id, err_len, route_sel, ost_count
  );
endinterface

// File: rtl/ar_chan_route_reg.sv
// ar_chan_route_reg: registered AR router with region decode, DECERR sink and same-target ordering stall
// Ports: ACLK clock, ARESET async active-high reset, bus (slave modport) with the upstream request,
//   per-slave AR outputs, DECERR handshake, rd_done, route_sel and ost_count.
module ar_chan_route_reg #(
  parameter int NUM_SLAVES = 4,
  parameter int ID_W = 1,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 8,
  parameter int BASE_W = 2,
  parameter logic [NUM_SLAVES-1:0] SLAVE_EN = {NUM_SLAVES{1'b1}},
  parameter int MAX_OST = 4
) (
  input logic ACLK,
  input logic ARESET,
  ar_chan_route_reg_if.slave bus
);
  localparam int OST_W = $clog2(MAX_OST + 1);
  localparam int TGT_W = $clog2(NUM_SLAVES + 1);
  localparam int NREG = 1 << BASE_W;
  localparam int SEL_W = NUM_SLAVES + 1;
  typedef enum logic [1:0] {EMPTY, STALL, ISSUE, ERR} state_t;
  state_t r_state;
  logic r_live;
  logic [ID_W-1:0] r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_len;
  logic [2:0] r_size, r_prot;
  logic [1:0] r_burst, r_lock;
  logic [3:0] r_cache, r_qos, r_region;
  logic [TGT_W-1:0] r_tgt, r_last_tgt;
  logic [OST_W-1:0] r_ost;
  logic [NREG-1:0] w_en;
  logic [BASE_W-1:0] w_idx;
  logic [TGT_W-1:0] w_tgt;
  logic w_cap, w_hs, w_dec;
  function automatic state_t route(input logic [TGT_W-1:0] t, input logic [OST_W-1:0] ost,
                                   input logic [TGT_W-1:0] last);
    return (ost == OST_W'(MAX_OST) || (ost != '0 && t != last)) ? STALL :
           (t == TGT_W'(NUM_SLAVES) ? ERR : ISSUE);
  endfunction
  // zero-extended enable mask makes regions beyond NUM_SLAVES decode to the error sink
  assign w_en = NREG'(SLAVE_EN);
  assign w_idx = bus.in_araddr[ADDR_W-1 -: BASE_W];
  assign w_tgt = w_en[w_idx] ? TGT_W'(w_idx) : TGT_W'(NUM_SLAVES);
  // r_live keeps in_arready low while reset is held
  assign bus.in_arready = r_live && r_state == EMPTY;
  assign w_cap = bus.in_arvalid && bus.in_arready;
  assign w_hs = (|(bus.m_arvalid & bus.m_arready)) || (bus.err_valid && bus.err_ready);
  assign w_dec = bus.rd_done && r_ost != '0;
  assign bus.err_valid = r_state == ERR;
  assign bus.err_id = r_id;
  assign bus.err_len = r_len;
  assign bus.ost_count = r_ost;
  assign bus.route_sel = r_ost != '0 ? SEL_W'(1) << r_last_tgt : '0;
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slv
    assign bus.m_arvalid[k] = r_state == ISSUE && r_tgt == TGT_W'(k);
    assign bus.m_arid[k*ID_W +: ID_W] = bus.m_arvalid[k] ? r_id : '0;
    assign bus.m_araddr[k*ADDR_W +: ADDR_W] = bus.m_arvalid[k] ? r_addr : '0;
    assign bus.m_arlen[k*LEN_W +: LEN_W] = bus.m_arvalid[k] ? r_len : '0;
    assign bus.m_arsize[k*3 +: 3] = bus.m_arvalid[k] ? r_size : '0;
    assign bus.m_arburst[k*2 +: 2] = bus.m_arvalid[k] ? r_burst : '0;
    assign bus.m_arlock[k*2 +: 2] = bus.m_arvalid[k] ? r_lock : '0;
    assign bus.m_arcache[k*4 +: 4] = bus.m_arvalid[k] ? r_cache : '0;
    assign bus.m_arprot[k*3 +: 3] = bus.m_arvalid[k] ? r_prot : '0;
    assign bus.m_arqos[k*4 +: 4] = bus.m_arvalid[k] ? r_qos : '0;
    assign bus.m_arregion[k*4 +: 4] = bus.m_arvalid[k] ? r_region : '0;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= EMPTY;
      r_live <= 1'b0;
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_lock <= '0;
      r_cache <= '0;
      r_prot <= '0;
      r_qos <= '0;
      r_region <= '0;
      r_tgt <= '0;
      r_last_tgt <= '0;
      r_ost <= '0;
    end else begin
      r_live <= 1'b1;
      r_ost <= r_ost + OST_W'(w_hs) - OST_W'(w_dec);
      if (w_hs) r_last_tgt <= r_tgt;
      if (w_cap) begin
        r_id <= bus.in_arid;
        r_addr <= bus.in_araddr;
        r_len <= bus.in_arlen;
        r_size <= bus.in_arsize;
        r_burst <= bus.in_arburst;
        r_lock <= bus.in_arlock;
        r_cache <= bus.in_arcache;
        r_prot <= bus.in_arprot;
        r_qos <= bus.in_arqos;
        r_region <= bus.in_arregion;
        r_tgt <= w_tgt;
        r_state <= route(w_tgt, r_ost, r_last_tgt);
      end else if (r_state == STALL) r_state <= route(r_tgt, r_ost, r_last_tgt);
      else if (w_hs) r_state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_ar_chan_route_reg.sv
// tb_ar_chan_route_reg: directed vectors with hand-computed expectations for the AR router
module tb_ar_chan_route_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  ar_chan_route_reg_if bus ();
  ar_chan_route_reg #(.SLAVE_EN(4'b0111)) dut (.ACLK(clk), .ARESET(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic req(input logic [31:0] a, input logic id, input logic [7:0] len);
    bus.in_araddr = a;
    bus.in_arid = id;
    bus.in_arlen = len;
    bus.in_arvalid = 1'b1;
    tick();
    bus.in_arvalid = 1'b0;
  endtask
  initial begin
    bus.in_arid = '0;
    bus.in_araddr = '0;
    bus.in_arlen = '0;
    bus.in_arsize = 3'd2;
    bus.in_arburst = 2'd1;
    bus.in_arlock = '0;
    bus.in_arcache = 4'h3;
    bus.in_arprot = 3'b101;
    bus.in_arqos = '0;
    bus.in_arregion = '0;
    bus.in_arvalid = 1'b0;
    bus.m_arready = '0;
    bus.err_ready = 1'b0;
    bus.rd_done = 1'b0;
    tick();
    tick();
    chk("rst_mvalid", bus.m_arvalid, 0);
    chk("rst_errvalid", bus.err_valid, 0);
    chk("rst_arready", bus.in_arready, 0);
    chk("rst_sel", bus.route_sel, 0);
    rst = 1'b0;
    tick();
    chk("rel_arready", bus.in_arready, 1);
    chk("rel_ost", bus.ost_count, 0);
    // slave 2 read
    bus.m_arready = 4'b0100;
    req(32'h8000_0010, 1'b0, 8'd3);
    chk("s2_valid", bus.m_arvalid, 4'b0100);
    chk("s2_addr", bus.m_araddr[64 +: 32], 32'h8000_0010);
    chk("s2_len", bus.m_arlen[16 +: 8], 3);
    chk("s2_prot", bus.m_arprot[6 +: 3], 3'b101);
    chk("s2_other_addr", bus.m_araddr[0 +: 32], 0);
    chk("s2_arready", bus.in_arready, 0);
    tick();
    chk("s2_done_valid", bus.m_arvalid, 0);
    chk("s2_ost", bus.ost_count, 1);
    chk("s2_sel", bus.route_sel, 5'b00100);
    chk("s2_arready", bus.in_arready, 1);
    // target switch to slave 1 stalls until the slave-2 read drains
    bus.m_arready = 4'b0010;
    req(32'h4000_0000, 1'b0, 8'd0);
    chk("sw_stall0", bus.m_arvalid, 0);
    chk("sw_arready", bus.in_arready, 0);
    tick();
    chk("sw_stall1", bus.m_arvalid, 0);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("sw_ost0", bus.ost_count, 0);
    chk("sw_stall2", bus.m_arvalid, 0);
    tick();
    chk("sw_valid", bus.m_arvalid, 4'b0010);
    chk("sw_addr", bus.m_araddr[32 +: 32], 32'h4000_0000);
    tick();
    chk("sw_ost1", bus.ost_count, 1);
    chk("sw_sel", bus.route_sel, 5'b00010);
    bus.m_arready = '0;
    bus.rd_done = 1'b1;
    tick();
    chk("drain_ost", bus.ost_count, 0);
    chk("drain_sel", bus.route_sel, 0);
    tick();
    bus.rd_done = 1'b0;
    chk("underflow", bus.ost_count, 0);
    // disabled region 3 goes to the DECERR sink
    req(32'hC000_0000, 1'b1, 8'd7);
    chk("err_valid", bus.err_valid, 1);
    chk("err_id", bus.err_id, 1);
    chk("err_len", bus.err_len, 7);
    chk("err_mvalid", bus.m_arvalid, 0);
    tick();
    chk("err_hold", bus.err_valid, 1);
    bus.err_ready = 1'b1;
    tick();
    bus.err_ready = 1'b0;
    chk("err_done", bus.err_valid, 0);
    chk("err_sel", bus.route_sel, 5'b10000);
    chk("err_ost", bus.ost_count, 1);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("err_drain", bus.ost_count, 0);
    // fill to MAX_OST on slave 0
    bus.m_arready = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req(32'h0000_0100 + i, 1'b0, 8'd1);
      tick();
    end
    chk("full_ost", bus.ost_count, 4);
    chk("full_sel", bus.route_sel, 5'b00001);
    req(32'h0000_0200, 1'b0, 8'd1);
    chk("full_stall0", bus.m_arvalid, 0);
    tick();
    chk("full_stall1", bus.m_arvalid, 0);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("full_ost3", bus.ost_count, 3);
    chk("full_stall2", bus.m_arvalid, 0);
    tick();
    chk("full_issue", bus.m_arvalid, 4'b0001);
    chk("full_issue_addr", bus.m_araddr[0 +: 32], 32'h0000_0200);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("both_ost", bus.ost_count, 3);
    req(32'h0000_0300, 1'b0, 8'd1);
    chk("same_tgt_issue", bus.m_arvalid, 4'b0001);
    tick();
    chk("refill_ost", bus.ost_count, 4);
    // backpressure on slave 0 with 3 outstanding, then reset mid-hold
    bus.m_arready = '0;
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    bus.in_arlen = 8'd5;
    req(32'h1234_5678, 1'b1, 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.m_arvalid, 4'b0001);
      chk("bp_addr", bus.m_araddr[0 +: 32], 32'h1234_5678);
      chk("bp_id", bus.m_arid[0], 1);
      chk("bp_arready", bus.in_arready, 0);
      tick();
    end
    chk("bp_ost", bus.ost_count, 3);
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.m_arvalid, 0);
    chk("arst_addr", bus.m_araddr, 0);
    chk("arst_ost", bus.ost_count, 0);
    chk("arst_sel", bus.route_sel, 0);
    chk("arst_arready", bus.in_arready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_arready", bus.in_arready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
